// File: rtl/pam_mrport.sv
// Multi-read-port register PAM with byte-enabled write, optional write-to-read bypass and a clear sequencer.
// Read latency 1 cycle per port; writes are visible to reads issued the next cycle (or the same cycle when BYPASS=1).
// No backpressure: reads/writes are ignored while busy (clear sweep); out-of-range accesses set a sticky err.
module pam_mrport #(
  parameter int                WIDTH      = 64,
  parameter int                BYTE       = 8,
  parameter int                DEPTH      = 14,
  parameter int                ADDR_WIDTH = 4,
  parameter int                NUM_RD     = 3,
  parameter int                BYPASS     = 1,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  output logic                         busy,
  input  logic [NUM_RD-1:0]            re,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0]      rdata,
  output logic [NUM_RD-1:0]            rvalid,
  input  logic                         we,
  input  logic [WIDTH/BYTE-1:0]        be,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         err
);

  localparam int                    LANES = WIDTH / BYTE;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  idle;
  logic                  wr_ok;
  logic [WIDTH-1:0]      wmask;
  logic [ADDR_WIDTH-1:0] ra      [NUM_RD];
  logic [WIDTH-1:0]      rd_next [NUM_RD];
  logic [NUM_RD-1:0]     rd_oor;

  assign idle  = (state == ST_IDLE);
  assign busy  = (state == ST_CLEAR);
  assign wr_ok = idle && we && (waddr <= LAST);

  // Expand byte enables into a bit mask used by both the write and the bypass merge.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < LANES; b++) begin
      wmask[b*BYTE +: BYTE] = {BYTE{be[b]}};
    end
  end

  // Clear sequencer: sweeps every entry once after reset or an init pulse taken in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state <= ST_IDLE;
          end else begin
            ptr <= ptr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          if (init) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  // Storage array: cleared entry by entry during the sweep, byte-merged writes in IDLE; no reset on data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[ptr] <= INIT_VALUE;
      end else if (wr_ok) begin
        mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
      end
    end
  end

  // Per-port read data: out-of-range reads return zero; same-cycle write is merged in when bypass is on.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p]      = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_oor[p]  = (ra[p] > LAST);
      rd_next[p] = '0;
      if (!rd_oor[p]) begin
        rd_next[p] = mem[ra[p]];
        if ((BYPASS != 0) && wr_ok && (waddr == ra[p])) begin
          rd_next[p] = (mem[ra[p]] & ~wmask) | (wdata & wmask);
        end
      end
    end
  end

  // Registered read outputs and the sticky out-of-range flag; both frozen while the sweep runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= '0;
      if (idle) begin
        for (int p = 0; p < NUM_RD; p++) begin
          if (re[p]) begin
            rdata[p*WIDTH +: WIDTH] <= rd_next[p];
            rvalid[p]               <= 1'b1;
            if (rd_oor[p]) begin
              err <= 1'b1;
            end
          end
        end
        if (we && (waddr > LAST)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
